// File: rtl/main_fifo_push_ctrl_if.sv
// main_fifo_push_ctrl_if
//   Bundles the upstream word stream, the Main FIFO status flags and the
//   push/back-pressure outputs of the Main FIFO write-side controller.
//   master : the push controller itself.
//   slave  : the environment (upstream source plus Main FIFO).
interface main_fifo_push_ctrl_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
);

  // Upstream word stream
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;

  // Main FIFO status
  logic                  Main_almost_full;
  logic                  Main_full;

  // Push side towards the Main FIFO
  logic                  Main_wr;
  logic [DATA_WIDTH-1:0] Main_data_in;

  // Back-pressure and statistics
  logic                  pause;
  logic [CNT_WIDTH-1:0]  drop_count;

  modport master (
    input  data_in,
    input  valid_in,
    input  Main_almost_full,
    input  Main_full,
    output Main_wr,
    output Main_data_in,
    output pause,
    output drop_count
  );

  modport slave (
    output data_in,
    output valid_in,
    output Main_almost_full,
    output Main_full,
    input  Main_wr,
    input  Main_data_in,
    input  pause,
    input  drop_count
  );

endinterface : main_fifo_push_ctrl_if

// File: rtl/main_fifo_push_ctrl.sv
// main_fifo_push_ctrl
//   Write-side controller for the Main FIFO. Accepts a valid-qualified word
//   stream and issues registered Main_wr / Main_data_in pushes only while the
//   FIFO reports room (neither almost-full nor full). A 2-entry skid buffer
//   covers the one-cycle lag of the registered pause back-pressure; words
//   arriving while the skid buffer is full and the FIFO has no room are
//   dropped.
//
//   Optional feature macro: MAIN_PUSH_DROP_CNT_EN
//     defined   : drop_count is a saturating counter of dropped words.
//     undefined : drop_count is tied to zero; drops still happen silently.
module main_fifo_push_ctrl #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_L,
  main_fifo_push_ctrl_if.master bus
);

  // Skid buffer occupancy; skid0 always holds the oldest buffered word.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e                  occ_q,       occ_d;
  logic [DATA_WIDTH-1:0] skid0_q,     skid0_d;
  logic [DATA_WIDTH-1:0] skid1_q,     skid1_d;
  logic                  main_wr_q,   main_wr_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  pause_q,     pause_d;

  logic                  can_wr;
  logic                  buffered;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;

  // Almost-full is the real stop condition: the strobe is registered, so the
  // FIFO needs one entry of margin. Full is honoured as a safety net.
  assign can_wr     = !bus.Main_almost_full && !bus.Main_full;

  // The head is the oldest word available: buffered words go first so no
  // fresh word can overtake them.
  assign buffered   = (occ_q != OCC_EMPTY);
  assign head_valid = buffered || bus.valid_in;
  assign head       = buffered ? skid0_q : bus.data_in;
  assign push       = can_wr && head_valid;

  // Next-state decode for occupancy, skid contents and registered outputs.
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    occ_d   = occ_q;
    skid0_d = skid0_q;
    skid1_d = skid1_q;

    unique case (occ_q)
      OCC_EMPTY: begin
        // With room the incoming word is pushed straight through.
        if (bus.valid_in && !can_wr) begin
          skid0_d = bus.data_in;
          occ_d   = OCC_ONE;
        end
      end

      OCC_ONE: begin
        if (can_wr) begin
          if (bus.valid_in) begin
            // skid0 leaves, the incoming word takes its place.
            skid0_d = bus.data_in;
          end else begin
            occ_d   = OCC_EMPTY;
          end
        end else if (bus.valid_in) begin
          skid1_d = bus.data_in;
          occ_d   = OCC_TWO;
        end
      end

      OCC_TWO: begin
        if (can_wr) begin
          // skid0 leaves, skid1 moves up to become the oldest word.
          skid0_d = skid1_q;
          if (bus.valid_in) begin
            skid1_d = bus.data_in;
          end else begin
            occ_d   = OCC_ONE;
          end
        end
        // No room and a new word: it is dropped, contents unchanged.
      end

      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase

    main_wr_d   = push;
    main_data_d = push ? head : '0;
    pause_d     = (occ_d != OCC_EMPTY);
  end

  // Occupancy FSM, skid registers and registered push/pause outputs.
  // NOTE: the two skid words are reset along with the control state so a
  // cleared buffer never exposes stale data, even though occupancy alone
  // would be enough to keep them from being pushed.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      occ_q       <= OCC_EMPTY;
      skid0_q     <= '0;
      skid1_q     <= '0;
      main_wr_q   <= 1'b0;
      main_data_q <= '0;
      pause_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      occ_q       <= occ_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      main_wr_q   <= main_wr_d;
      main_data_q <= main_data_d;
      pause_q     <= pause_d;
    end
  end

  assign bus.Main_wr      = main_wr_q;
  assign bus.Main_data_in = main_data_q;
  assign bus.pause        = pause_q;

`ifdef MAIN_PUSH_DROP_CNT_EN
  logic                 drop;
  logic [CNT_WIDTH-1:0] drop_count_q;
  logic [CNT_WIDTH-1:0] drop_count_d;

  // A word is lost only when both skid entries are taken and there is no room.
  assign drop = (occ_q == OCC_TWO) && bus.valid_in && !can_wr;

  // Saturate rather than wrap so a large count never reads back as small.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != {CNT_WIDTH{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_WIDTH'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      drop_count_q <= '0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign bus.drop_count = drop_count_q;
`else
  assign bus.drop_count = {CNT_WIDTH{1'b0}};
`endif

endmodule : main_fifo_push_ctrl

// File: tb/tb_main_fifo_push_ctrl.sv
// tb_main_fifo_push_ctrl
//   Directed bench for main_fifo_push_ctrl. A second instance with a 2-bit
//   drop counter exercises counter saturation. Expected drop counts follow
//   MAIN_PUSH_DROP_CNT_EN.
module tb_main_fifo_push_ctrl;

  localparam int DW = 6;

`ifdef MAIN_PUSH_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk;
  logic reset_L;

  int n_checks = 0;
  int n_fail   = 0;

  main_fifo_push_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) bus ();
  main_fifo_push_ctrl_if #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) sbus ();

  main_fifo_push_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(8)) u_dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  main_fifo_push_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(2)) u_sat (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic af, input logic full);
    bus.valid_in         = v;
    bus.data_in          = d;
    bus.Main_almost_full = af;
    bus.Main_full        = full;
  endtask

  // {Main_wr, Main_data_in, pause} packed for one-line comparisons.
  function automatic logic [DW+1:0] obs();
    return {bus.Main_wr, bus.Main_data_in, bus.pause};
  endfunction

  function automatic logic [DW+1:0] exp_v(input logic wr, input logic [DW-1:0] d,
                                          input logic p);
    return {wr, d, p};
  endfunction

  task automatic test_reset();
    reset_L = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    sbus.valid_in = 1'b0; sbus.data_in = '0;
    sbus.Main_almost_full = 1'b0; sbus.Main_full = 1'b0;
    #2;
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
    n_checks++;
    if (bus.drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_drop_count: got %0d, want 0", bus.drop_count);
    end
    tick();
    tick();
    #2 reset_L = 1'b1;
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_idle_after_release: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, DW'(k), 1'b0, 1'b0);
      tick();
      n_checks++;
      if (obs() !== exp_v(1'b1, DW'(k), 1'b0)) begin
        n_fail++;
        $display("FAIL stream_word_%0d: got %b, want %b", k, obs(), exp_v(1'b1, DW'(k), 1'b0));
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL stream_idle: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
  endtask

  task automatic test_back_pressure();
    // Almost-full rises with 0x0A: no push next cycle, pause raised.
    drive(1'b1, 6'h0A, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_first: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b1));
    end
    drive(1'b1, 6'h0B, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_second: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v(1'b0, '0, 1'b1)) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got %b, want %b", i, obs(), exp_v(1'b0, '0, 1'b1));
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h0A, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_drain_0A: got %b, want %b", obs(), exp_v(1'b1, 6'h0A, 1'b1));
    end
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h0B, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_drain_0B: got %b, want %b", obs(), exp_v(1'b1, 6'h0B, 1'b0));
    end
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_idle: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
  endtask

  task automatic test_push_and_store();
    logic [DW-1:0] words [3];
    // ONE state with valid and room: push skid0, incoming word replaces it.
    drive(1'b1, 6'h31, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'h32, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h31, 1'b1)) begin
      n_fail++;
      $display("FAIL one_push_store: got %b, want %b", obs(), exp_v(1'b1, 6'h31, 1'b1));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h32, 1'b0)) begin
      n_fail++;
      $display("FAIL one_drain: got %b, want %b", obs(), exp_v(1'b1, 6'h32, 1'b0));
    end
    // TWO state with valid and room: push, shift, store.
    drive(1'b1, 6'h34, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'h35, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'h36, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h34, 1'b1)) begin
      n_fail++;
      $display("FAIL two_push_store: got %b, want %b", obs(), exp_v(1'b1, 6'h34, 1'b1));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    words = '{6'h35, 6'h36, 6'h00};
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs() !== exp_v(i < 2, words[i], i == 0)) begin
        n_fail++;
        $display("FAIL two_drain_%0d: got %b, want %b", i, obs(), exp_v(i < 2, words[i], i == 0));
      end
    end
  endtask

  task automatic test_overflow();
    // Upstream ignores pause: 0x11, 0x12 buffered, 0x13..0x15 dropped.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, DW'(6'h11 + k), 1'b1, 1'b0);
      tick();
      n_checks++;
      if (obs() !== exp_v(1'b0, '0, 1'b1)) begin
        n_fail++;
        $display("FAIL ovf_nopush_%0d: got %b, want %b", k, obs(), exp_v(1'b0, '0, 1'b1));
      end
    end
    n_checks++;
    if (bus.drop_count !== (CNT_EN ? 8'd3 : 8'd0)) begin
      n_fail++;
      $display("FAIL ovf_drop_count: got %0d, want %0d", bus.drop_count, CNT_EN ? 3 : 0);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h11, 1'b1)) begin
      n_fail++;
      $display("FAIL ovf_drain_11: got %b, want %b", obs(), exp_v(1'b1, 6'h11, 1'b1));
    end
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h12, 1'b0)) begin
      n_fail++;
      $display("FAIL ovf_drain_12: got %b, want %b", obs(), exp_v(1'b1, 6'h12, 1'b0));
    end
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL ovf_idle: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
  endtask

  task automatic test_full_only();
    drive(1'b1, 6'h3F, 1'b0, 1'b1);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b1)) begin
      n_fail++;
      $display("FAIL full_store: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b1));
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    tick();
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b1)) begin
      n_fail++;
      $display("FAIL full_hold: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b1));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h3F, 1'b0)) begin
      n_fail++;
      $display("FAIL full_release: got %b, want %b", obs(), exp_v(1'b1, 6'h3F, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    // Fill to TWO and drop one more, then reset asynchronously.
    drive(1'b1, 6'h21, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'h22, 1'b1, 1'b0);
    tick();
    drive(1'b1, 6'h23, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 reset_L = 1'b0;
    #1;
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
    n_checks++;
    if (bus.drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_drop_count: got %0d, want 0", bus.drop_count);
    end
    #2 reset_L = 1'b1;
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b0, '0, 1'b0)) begin
      n_fail++;
      $display("FAIL rstmid_discard: got %b, want %b", obs(), exp_v(1'b0, '0, 1'b0));
    end
    drive(1'b1, 6'h15, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (obs() !== exp_v(1'b1, 6'h15, 1'b0)) begin
      n_fail++;
      $display("FAIL rstmid_first_push: got %b, want %b", obs(), exp_v(1'b1, 6'h15, 1'b0));
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    // 2 words buffered, then 6 drops on the 2-bit counter.
    sbus.Main_almost_full = 1'b1;
    sbus.Main_full        = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sbus.valid_in = 1'b1;
      sbus.data_in  = DW'(k + 1);
      tick();
      want = CNT_EN ? ((k < 2) ? 2'd0 : (k - 1 >= 3) ? 2'd3 : 2'(k - 1)) : 2'd0;
      n_checks++;
      if (sbus.drop_count !== want) begin
        n_fail++;
        $display("FAIL sat_count_%0d: got %0d, want %0d", k, sbus.drop_count, want);
      end
    end
    sbus.valid_in         = 1'b0;
    sbus.Main_almost_full = 1'b0;
    tick();
    n_checks++;
    if ({sbus.Main_wr, sbus.Main_data_in} !== {1'b1, 6'h01}) begin
      n_fail++;
      $display("FAIL sat_drain_first: got %b, want %b", {sbus.Main_wr, sbus.Main_data_in}, {1'b1, 6'h01});
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_push_and_store();
    test_overflow();
    test_full_only();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_main_fifo_push_ctrl
